// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline register with committed status-flag register (SR).
// Optional instruction counter enabled by defining EXE_MEM_PERF_CNT_EN.
module exe_mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        valid_in,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic        S_in,
   input  logic [3:0]  Dest_in,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] Val_Rm_in,
   input  logic [3:0]  status_in,
   output logic        valid_out,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [3:0]  Dest,
   output logic [31:0] ALU_result,
   output logic [31:0] Val_Rm,
   output logic [3:0]  SR
`ifdef EXE_MEM_PERF_CNT_EN
   ,
   output logic [31:0] inst_count
`endif
);

   logic accept;
   logic advance;

   assign accept  = ~stall & valid_in & ~flush;
   assign advance = ~stall;

   // Control bits are gated by accept so a killed slot becomes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out  <= 1'b0;
         WB_EN      <= 1'b0;
         MEM_R_EN   <= 1'b0;
         MEM_W_EN   <= 1'b0;
         Dest       <= '0;
         ALU_result <= '0;
         Val_Rm     <= '0;
      end else if (advance) begin
         valid_out  <= accept;
         WB_EN      <= WB_EN_in & accept;
         MEM_R_EN   <= MEM_R_EN_in & accept;
         MEM_W_EN   <= MEM_W_EN_in & accept;
         Dest       <= Dest_in;
         ALU_result <= ALU_result_in;
         Val_Rm     <= Val_Rm_in;
      end
   end

   // SR is registered only; it feeds the ALU carry-in so no bypass path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SR <= '0;
      end else if (accept && S_in) begin
         SR <= status_in;
      end
   end

`ifdef EXE_MEM_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_count <= '0;
      end else if (accept) begin
         inst_count <= inst_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage; perf-counter checks need EXE_MEM_PERF_CNT_EN.
module tb_exe_mem_stage;

   typedef struct packed {
      logic        v;
      logic        wb;
      logic        mr;
      logic        mw;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] rm;
      logic [3:0]  sr;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
   logic        WB_EN_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0, S_in = 1'b0;
   logic [3:0]  Dest_in = '0;
   logic [31:0] ALU_result_in = '0, Val_Rm_in = '0;
   logic [3:0]  status_in = '0;
   logic        valid_out, WB_EN, MEM_R_EN, MEM_W_EN;
   logic [3:0]  Dest, SR;
   logic [31:0] ALU_result, Val_Rm;
`ifdef EXE_MEM_PERF_CNT_EN
   logic [31:0] inst_count;
   logic [31:0] m_cnt;
`endif

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   out_t m;
   out_t e;
   out_t act;
   out_t sb[$];

   assign act = {valid_out, WB_EN, MEM_R_EN, MEM_W_EN, Dest, ALU_result, Val_Rm, SR};

   exe_mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
      .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
      .S_in(S_in), .Dest_in(Dest_in), .ALU_result_in(ALU_result_in),
      .Val_Rm_in(Val_Rm_in), .status_in(status_in),
      .valid_out(valid_out), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .Dest(Dest), .ALU_result(ALU_result), .Val_Rm(Val_Rm), .SR(SR)
`ifdef EXE_MEM_PERF_CNT_EN
      , .inst_count(inst_count)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, push the expected registered outputs, wait past the edge.
   task automatic step(input logic st, input logic fl, input logic vi, input logic wb,
                       input logic mr, input logic mw, input logic s, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] sts);
      logic acc;
      stall = st; flush = fl; valid_in = vi; WB_EN_in = wb; MEM_R_EN_in = mr;
      MEM_W_EN_in = mw; S_in = s; Dest_in = d; ALU_result_in = alu; Val_Rm_in = rm;
      status_in = sts;
      acc = !st && vi && !fl;
      if (!st) begin
         m.v = acc; m.wb = wb && acc; m.mr = mr && acc; m.mw = mw && acc;
         m.dest = d; m.alu = alu; m.rm = rm;
      end
      if (acc && s) m.sr = sts;
`ifdef EXE_MEM_PERF_CNT_EN
      if (acc) m_cnt = m_cnt + 32'd1;
`endif
      sb.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic pop_exp(output out_t x);
      if (sb.size() == 0) begin
         x = 'x;
         $display("FAIL scoreboard_empty: no expected entry queued");
         miscompares++;
      end else begin
         x = sb.pop_front();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      m = '0;
`ifdef EXE_MEM_PERF_CNT_EN
      m_cnt = '0;
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (act !== out_t'('0)) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", act, out_t'('0));
      end
`ifdef EXE_MEM_PERF_CNT_EN
      vectors++;
      if (inst_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %h want 0", inst_count);
      end
`endif
      m = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic_advance();
      step(0, 0, 1, 1, 0, 0, 1, 4'h3, 32'h0000_0005, 32'h1234_5678, 4'b0000);
      pop_exp(e);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL basic_advance: got %h want %h", act, e);
      end
      vectors++;
      if (ALU_result !== 32'd5 || valid_out !== 1'b1 || SR !== 4'b0000) begin
         miscompares++;
         $display("FAIL basic_fields: alu=%h v=%b sr=%b want 5/1/0000", ALU_result, valid_out, SR);
      end
      step(0, 0, 1, 0, 1, 1, 1, 4'h7, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1001);
      pop_exp(e);
      vectors++;
      if (act !== e || SR !== 4'b1001) begin
         miscompares++;
         $display("FAIL basic_second: got %h want %h", act, e);
      end
   endtask

   task automatic test_flag_guard();
      step(0, 0, 1, 1, 0, 0, 0, 4'h2, 32'h0000_0042, 32'h0, 4'b0110);
      pop_exp(e);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL flag_guard: got %h want %h", act, e);
      end
      vectors++;
      if (SR !== 4'b1001 || valid_out !== 1'b1) begin
         miscompares++;
         $display("FAIL flag_guard_sr: sr=%b v=%b want 1001/1", SR, valid_out);
      end
   endtask

   task automatic test_flush();
      step(0, 1, 1, 1, 1, 1, 1, 4'h5, 32'h0000_0099, 32'h0, 4'b1000);
      pop_exp(e);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL flush: got %h want %h", act, e);
      end
      vectors++;
      if (valid_out !== 1'b0 || WB_EN !== 1'b0 || MEM_W_EN !== 1'b0 || SR !== 4'b1001) begin
         miscompares++;
         $display("FAIL flush_bubble: v=%b wb=%b mw=%b sr=%b want 0/0/0/1001",
                  valid_out, WB_EN, MEM_W_EN, SR);
      end
   endtask

   task automatic test_stall_flush();
      step(0, 0, 1, 1, 0, 0, 1, 4'hA, 32'h0000_00AA, 32'h0000_0BBB, 4'b0101);
      pop_exp(e);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL stall_flush_load: got %h want %h", act, e);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 0, 1, 1, 1, 4'h3, 32'h1111_1111, 32'h2222_2222, 4'b1111);
         pop_exp(e);
         vectors++;
         if (act !== e || Dest !== 4'hA || valid_out !== 1'b1 || SR !== 4'b0101) begin
            miscompares++;
            $display("FAIL stall_flush_hold[%0d]: got %h want %h", i, act, e);
         end
      end
      step(0, 1, 1, 1, 1, 1, 1, 4'h3, 32'h1111_1111, 32'h2222_2222, 4'b1111);
      pop_exp(e);
      vectors++;
      if (act !== e || valid_out !== 1'b0 || SR !== 4'b0101) begin
         miscompares++;
         $display("FAIL stall_flush_release: got %h want %h", act, e);
      end
   endtask

   task automatic test_async_reset();
      step(0, 0, 1, 1, 1, 0, 1, 4'hC, 32'h0BAD_CAFE, 32'h0000_0001, 4'b1111);
      pop_exp(e);
      vectors++;
      if (act !== e || SR !== 4'b1111 || valid_out !== 1'b1) begin
         miscompares++;
         $display("FAIL async_pre: got %h want %h", act, e);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (act !== out_t'('0)) begin
         miscompares++;
         $display("FAIL async_reset: got %h want %h", act, out_t'('0));
      end
      m = '0;
`ifdef EXE_MEM_PERF_CNT_EN
      m_cnt = '0;
`endif
      @(negedge clk);
      rst = 1'b0;
      // reset during a stall drops the held instruction
      step(0, 0, 1, 1, 0, 1, 1, 4'h9, 32'h0000_0077, 32'h0000_0088, 4'b0011);
      pop_exp(e);
      step(1, 0, 1, 0, 0, 0, 0, 4'h1, 32'h0, 32'h0, 4'b0000);
      pop_exp(e);
      do_reset();
      vectors++;
      if (act !== out_t'('0)) begin
         miscompares++;
         $display("FAIL reset_mid_stall: got %h want %h", act, out_t'('0));
      end
      step(0, 0, 1, 0, 1, 0, 1, 4'h6, 32'h0000_0123, 32'h0000_0456, 4'b0010);
      pop_exp(e);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL first_after_reset: got %h want %h", act, e);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              $urandom, $urandom, 4'($urandom));
         pop_exp(e);
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got %h want %h", i, act, e);
         end
`ifdef EXE_MEM_PERF_CNT_EN
         vectors++;
         if (inst_count !== m_cnt) begin
            miscompares++;
            $display("FAIL count_track[%0d]: got %h want %h", i, inst_count, m_cnt);
         end
`endif
      end
   endtask

`ifdef EXE_MEM_PERF_CNT_EN
   task automatic test_perf_cnt();
      @(negedge clk);
      force dut.inst_count = 32'hFFFF_FFFF;
      #1 release dut.inst_count;
      m_cnt = 32'hFFFF_FFFF;
      step(0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000);
      pop_exp(e);
      vectors++;
      if (inst_count !== 32'd0) begin
         miscompares++;
         $display("FAIL count_wrap: got %h want 0", inst_count);
      end
      step(1, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000);
      pop_exp(e);
      step(0, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000);
      pop_exp(e);
      vectors++;
      if (inst_count !== 32'd0) begin
         miscompares++;
         $display("FAIL count_no_inc: got %h want 0", inst_count);
      end
      step(0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000);
      pop_exp(e);
      vectors++;
      if (inst_count !== 32'd1) begin
         miscompares++;
         $display("FAIL count_inc: got %h want 1", inst_count);
      end
   endtask
`endif

   initial begin
      m = '0;
`ifdef EXE_MEM_PERF_CNT_EN
      m_cnt = '0;
`endif
      test_reset();
      test_basic_advance();
      test_flag_guard();
      test_flush();
      test_stall_flush();
      test_async_reset();
      test_back_to_back();
`ifdef EXE_MEM_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
